// File: rtl/gray_step_counter_pkg.sv
// Shared helpers for the Gray step counter: Gray encoding, popcount for the
// single-bit-change self-check, and the all-ones terminal value per width.
package gray_step_counter_pkg;

  localparam int MAX_W = 16;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] value);
    return value ^ (value >> 1);
  endfunction

  function automatic logic [4:0] popcount(input logic [MAX_W-1:0] value);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + {4'b0000, value[i]};
    end
    return n;
  endfunction

  function automatic logic [MAX_W-1:0] max_val(input int width);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Purely combinational binary-to-Gray encoder of configurable width.
module gray_enc
  import gray_step_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  logic [MAX_W-1:0] gray_full;
  logic             unused_hi;

  assign gray_full = bin2gray(MAX_W'(bin));
  assign gray      = gray_full[WIDTH-1:0];
  // Upper bits are always zero for a zero-extended input.
  assign unused_hi = ^gray_full;

endmodule

// File: rtl/gray_step_counter.sv
// Up/down binary counter with load, wrap-or-saturate limits, a registered Gray
// copy taken from the same next value, terminal-count pulse and Gray self-check.
module gray_step_counter
  import gray_step_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             err
);

  localparam logic [MAX_W-1:0] MAX_FULL = max_val(WIDTH);
  localparam logic [WIDTH-1:0] MAX      = MAX_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             at_limit;
  logic             tc_next;
  logic             err_next;
  logic             changed;

  always_comb begin
    bin_next = bin;
    at_limit = 1'b0;
    if (load) begin
      bin_next = load_val;
    end else if (en) begin
      if (up) begin
        if (bin == MAX) begin
          at_limit = 1'b1;
          bin_next = WRAP ? '0 : bin;
        end else begin
          bin_next = bin + WIDTH'(1);
        end
      end else begin
        if (bin == '0) begin
          at_limit = 1'b1;
          bin_next = WRAP ? MAX : bin;
        end else begin
          bin_next = bin - WIDTH'(1);
        end
      end
    end
  end

  gray_enc #(.WIDTH(WIDTH)) u_gray_enc (
    .bin  (bin_next),
    .gray (gray_next)
  );

  // Only real step moves are checked; loads may jump arbitrarily in Gray space.
  assign changed  = en && !load && (bin_next != bin);
  assign tc_next  = en && !load && at_limit;
  assign err_next = changed && (popcount(MAX_W'(gray_next ^ gray)) != 5'd1);

  // Register stage: bin, gray, tc and err all update on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin  <= '0;
      gray <= '0;
      tc   <= 1'b0;
      err  <= 1'b0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
      tc   <= tc_next;
      err  <= err_next;
    end
  end

endmodule
